// File: rtl/drac_pkg.sv
// Shared types and helpers for the data-memory request/response path.
// Pure declarations; no timing and no flow control of its own.
// Used by the responder and by the lane alignment logic.
package drac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        XCPT
    } dmem_state_t;

    typedef logic [1:0] mem_size_t;

    localparam logic MEM_OP_LOAD  = 1'b0;
    localparam logic MEM_OP_STORE = 1'b1;

    localparam mem_size_t SIZE_B = 2'd0;
    localparam mem_size_t SIZE_H = 2'd1;
    localparam mem_size_t SIZE_W = 2'd2;
    localparam mem_size_t SIZE_D = 2'd3;

    // An access is misaligned when any address bit below its size is set.
    function automatic logic is_misaligned(input logic [2:0] lsb, input mem_size_t size);
        case (size)
            SIZE_H:  return lsb[0];
            SIZE_W:  return |lsb[1:0];
            SIZE_D:  return |lsb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: load extract/extend and store byte mask/data shift.
// Purely combinational, zero cycles.
// No flow control; outputs follow inputs.
module dmem_lane_align
    import drac_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  lane,
    input  logic        is_signed,
    input  logic [63:0] rd_word,
    input  logic [63:0] wdata,
    output logic [63:0] ld_data,
    output logic [7:0]  st_mask,
    output logic [63:0] st_data
);

    logic [5:0]  shamt;
    logic [63:0] shifted;

    assign shamt   = {lane, 3'b000};
    assign shifted = rd_word >> shamt;
    assign st_data = wdata << shamt;

    always_comb begin
        ld_data = shifted;
        st_mask = 8'hFF;
        case (size)
            SIZE_B: begin
                ld_data = {{56{is_signed & shifted[7]}}, shifted[7:0]};
                st_mask = 8'h01 << lane;
            end
            SIZE_H: begin
                ld_data = {{48{is_signed & shifted[15]}}, shifted[15:0]};
                st_mask = 8'h03 << lane;
            end
            SIZE_W: begin
                ld_data = {{32{is_signed & shifted[31]}}, shifted[31:0]};
                st_mask = 8'h0F << lane;
            end
            default: begin
                ld_data = shifted;
                st_mask = 8'hFF;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Scratchpad data-memory responder: one load/store in flight, alignment and range checked.
// Legal access: LATENCY wait cycles after accept, then a one-cycle response; exceptions respond the next cycle.
// Accepts only when idle (resp_ready_o); resp_lock_o stalls the core while a request is in flight.
module dmem_responder
    import drac_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned LATENCY   = 2,
    parameter logic [39:0] BASE_ADDR = 40'h0080000000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    input  logic        req_kill_i,
    input  logic [39:0] req_addr_i,
    input  logic        req_op_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_ready_o,
    output logic        resp_lock_o,
    output logic        resp_valid_o,
    output logic [63:0] resp_data_o,
    output logic        resp_xcpt_ma_ld_o,
    output logic        resp_xcpt_ma_st_o,
    output logic        resp_xcpt_af_o
);

    localparam int unsigned AW       = $clog2(MEM_BYTES);
    localparam int unsigned WORDS    = MEM_BYTES / 8;
    localparam logic [39:0] MEM_SPAN = 40'(MEM_BYTES);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [AW-4:0] idx_q;
    logic [2:0]    lane_q;
    logic          op_q;
    logic [1:0]    size_q;
    logic          sgn_q;
    logic [63:0]   wdata_q;
    logic          ma_ld_q, ma_st_q, af_q;

    logic [39:0] offset;
    logic        in_range;
    logic        misaligned;
    logic        accept;
    logic        access;

    logic [63:0] mem [WORDS];
    logic [63:0] rd_word_q;
    logic [63:0] ld_data;
    logic [7:0]  st_mask;
    logic [63:0] st_data;

    // Offset wraps for addresses below BASE_ADDR, so one compare covers both bounds.
    assign offset     = req_addr_i - BASE_ADDR;
    assign in_range   = offset < MEM_SPAN;
    assign misaligned = is_misaligned(offset[2:0], req_size_i);
    assign accept     = (state_q == IDLE) && req_valid_i && !req_kill_i;
    assign access     = (state_q == WAIT) && (cnt_q == 4'd0) && !req_kill_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (misaligned || !in_range) ? XCPT : WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (req_kill_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx_q   <= '0;
            lane_q  <= 3'd0;
            op_q    <= MEM_OP_LOAD;
            size_q  <= SIZE_B;
            sgn_q   <= 1'b0;
            wdata_q <= 64'd0;
            ma_ld_q <= 1'b0;
            ma_st_q <= 1'b0;
            af_q    <= 1'b0;
        end else if (accept) begin
            idx_q   <= offset[AW-1:3];
            lane_q  <= offset[2:0];
            op_q    <= req_op_i;
            size_q  <= req_size_i;
            sgn_q   <= req_signed_i;
            wdata_q <= req_wdata_i;
            ma_ld_q <= misaligned && (req_op_i == MEM_OP_LOAD);
            ma_st_q <= misaligned && (req_op_i == MEM_OP_STORE);
            af_q    <= !misaligned && !in_range;
        end
    end

    dmem_lane_align u_align (
        .size      (size_q),
        .lane      (lane_q),
        .is_signed (sgn_q),
        .rd_word   (rd_word_q),
        .wdata     (wdata_q),
        .ld_data   (ld_data),
        .st_mask   (st_mask),
        .st_data   (st_data)
    );

    // Scratchpad is left unreset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (access) begin
            rd_word_q <= mem[idx_q];
            if (op_q == MEM_OP_STORE) begin
                for (int b = 0; b < 8; b++) begin
                    if (st_mask[b]) begin
                        mem[idx_q][8*b +: 8] <= st_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign resp_ready_o      = (state_q == IDLE);
    assign resp_lock_o       = (state_q == WAIT);
    assign resp_valid_o      = (state_q == RESP) || (state_q == XCPT);
    assign resp_data_o       = ((state_q == RESP) && (op_q == MEM_OP_LOAD)) ? ld_data : 64'd0;
    assign resp_xcpt_ma_ld_o = (state_q == XCPT) && ma_ld_q;
    assign resp_xcpt_ma_st_o = (state_q == XCPT) && ma_st_q;
    assign resp_xcpt_af_o    = (state_q == XCPT) && af_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

    localparam int unsigned MEM_BYTES = 65536;
    localparam int unsigned LATENCY   = 2;
    localparam logic [39:0] BASE      = 40'h0080000000;
    localparam int          MDL_BYTES = 512;
    localparam logic        LD        = 1'b0;
    localparam logic        ST        = 1'b1;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_kill_i = 1'b0;
    logic [39:0] req_addr_i = '0;
    logic        req_op_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_signed_i = 1'b0;
    logic [63:0] req_wdata_i = '0;
    logic        resp_ready_o, resp_lock_o, resp_valid_o;
    logic [63:0] resp_data_o;
    logic        resp_xcpt_ma_ld_o, resp_xcpt_ma_st_o, resp_xcpt_af_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mdl [MDL_BYTES];

    always #5 clk_i = ~clk_i;

    dmem_responder #(
        .MEM_BYTES (MEM_BYTES),
        .LATENCY   (LATENCY),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .req_valid_i       (req_valid_i),
        .req_kill_i        (req_kill_i),
        .req_addr_i        (req_addr_i),
        .req_op_i          (req_op_i),
        .req_size_i        (req_size_i),
        .req_signed_i      (req_signed_i),
        .req_wdata_i       (req_wdata_i),
        .resp_ready_o      (resp_ready_o),
        .resp_lock_o       (resp_lock_o),
        .resp_valid_o      (resp_valid_o),
        .resp_data_o       (resp_data_o),
        .resp_xcpt_ma_ld_o (resp_xcpt_ma_ld_o),
        .resp_xcpt_ma_st_o (resp_xcpt_ma_st_o),
        .resp_xcpt_af_o    (resp_xcpt_af_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Little-endian gather of 2^size bytes, then extension.
    function automatic logic [63:0] mdl_load(input int off, input int size, input bit sgn);
        int n;
        logic [63:0] v;
        logic top;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[off + i];
        top = mdl[off + n - 1][7];
        for (int i = n; i < 8; i++) v[8*i +: 8] = (sgn && top) ? 8'hFF : 8'h00;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, " ready"}, 64'(resp_ready_o), 64'd1);
        chk({tag, " lock"},  64'(resp_lock_o),  64'd0);
        chk({tag, " valid"}, 64'(resp_valid_o), 64'd0);
        chk({tag, " data"},  resp_data_o,       64'd0);
        chk({tag, " xcpt"},  64'({resp_xcpt_ma_ld_o, resp_xcpt_ma_st_o, resp_xcpt_af_o}), 64'd0);
    endtask

    // One transaction. Latency counts clock edges from the accepting edge:
    // exceptions respond after 1, legal accesses after LATENCY wait cycles plus one.
    // kill_at > 0 raises kill in wait cycle kill_at (legal accesses only).
    task automatic txn(input string tag, input logic op, input logic [1:0] size, input bit sgn,
                       input logic [39:0] addr, input logic [63:0] wd, input int kill_at);
        logic [39:0] off;
        bit in_rng, ma, af, xc;
        int exp_lat, got;
        logic [63:0] exp_d;
        off     = addr - BASE;
        in_rng  = off < 40'(MEM_BYTES);
        ma      = (int'(addr[2:0]) % (1 << size)) != 0;
        af      = !ma && !in_rng;
        xc      = ma || af;
        exp_lat = xc ? 1 : LATENCY + 1;
        exp_d   = '0;
        if (!xc && op == LD) exp_d = mdl_load(int'(off), int'(size), sgn);

        @(negedge clk_i);
        chk({tag, " ready"}, 64'(resp_ready_o), 64'd1);
        req_valid_i  = 1'b1;
        req_op_i     = op;
        req_size_i   = size;
        req_signed_i = sgn;
        req_addr_i   = addr;
        req_wdata_i  = wd;

        if (kill_at > 0 && !xc) begin
            for (int n = 1; n <= kill_at; n++) begin
                @(negedge clk_i);
                chk({tag, " lock"},  64'(resp_lock_o),  64'd1);
                chk({tag, " valid"}, 64'(resp_valid_o), 64'd0);
            end
            req_kill_i = 1'b1;
            @(negedge clk_i);
            req_kill_i  = 1'b0;
            req_valid_i = 1'b0;
            check_idle_outputs({tag, " killed"});
            for (int n = 0; n < LATENCY + 2; n++) begin
                @(negedge clk_i);
                chk({tag, " no resp"}, 64'(resp_valid_o), 64'd0);
            end
            return;
        end

        got = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin
                got = n;
                break;
            end
            if (n == 1) chk({tag, " lock"}, 64'(resp_lock_o), 64'd1);
        end
        chk({tag, " lat"},   64'(got), 64'(exp_lat));
        chk({tag, " data"},  resp_data_o, exp_d);
        chk({tag, " ma_ld"}, 64'(resp_xcpt_ma_ld_o), 64'(ma && op == LD));
        chk({tag, " ma_st"}, 64'(resp_xcpt_ma_st_o), 64'(ma && op == ST));
        chk({tag, " af"},    64'(resp_xcpt_af_o),    64'(af));
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs({tag, " after"});

        if (!xc && op == ST) begin
            for (int i = 0; i < (1 << size); i++) mdl[int'(off) + i] = wd[8*i +: 8];
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        logic [39:0] a;
        logic [1:0]  sz;
        logic [63:0] wd;
        int r, kill;

        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;

        // Fill the modelled region so every later load has defined data.
        for (int w = 0; w < MDL_BYTES / 8; w++)
            txn("init", ST, 2'd3, 1'b0, BASE + 40'(8 * w), {$urandom, $urandom}, 0);

        txn("t1 st", ST, 2'd3, 1'b0, BASE + 40'h10, 64'h1122334455667788, 0);
        txn("t1 ld", LD, 2'd3, 1'b0, BASE + 40'h10, 64'd0, 0);
        txn("t2 stb", ST, 2'd0, 1'b0, BASE + 40'h13, 64'hAB, 0);
        txn("t2 lws", LD, 2'd2, 1'b1, BASE + 40'h10, 64'd0, 0);
        txn("t2 lwu", LD, 2'd2, 1'b0, BASE + 40'h10, 64'd0, 0);
        txn("t2 stbn", ST, 2'd0, 1'b0, BASE + 40'h13, 64'hF0, 0);
        txn("t2 lwsn", LD, 2'd2, 1'b1, BASE + 40'h10, 64'd0, 0);
        txn("t3 malh", LD, 2'd1, 1'b0, BASE + 40'h11, 64'd0, 0);
        txn("t3 ld", LD, 2'd3, 1'b0, BASE + 40'h10, 64'd0, 0);
        txn("t4 af", ST, 2'd2, 1'b0, 40'h0040000000, 64'hDEAD, 0);
        txn("t4 mast", ST, 2'd2, 1'b0, 40'h0040000002, 64'hDEAD, 0);
        txn("t4 alias", ST, 2'd3, 1'b0, BASE + 40'(MEM_BYTES) + 40'h10, 64'hCAFE, 0);
        txn("t5 kill", ST, 2'd3, 1'b0, BASE + 40'h10, 64'hFFEEDDCCBBAA9988, LATENCY);
        txn("t5 ld", LD, 2'd3, 1'b0, BASE + 40'h10, 64'd0, 0);

        // Reset in the middle of a store: no write, outputs back to reset values.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = ST;
        req_size_i  = 2'd3;
        req_addr_i  = BASE + 40'h18;
        req_wdata_i = 64'h0123456789ABCDEF;
        @(negedge clk_i);
        chk("t6 lock", 64'(resp_lock_o), 64'd1);
        rstn_i = 1'b0;
        #1;
        check_idle_outputs("t6 rst");
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        txn("t6 ld", LD, 2'd3, 1'b0, BASE + 40'h18, 64'd0, 0);

        for (int t = 0; t < 300; t++) begin
            sz = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      a = BASE + 40'(MEM_BYTES) + 40'($urandom_range(0, MDL_BYTES - 1));
            else if (r == 1) a = BASE - 40'd1 - 40'($urandom_range(0, 63));
            else if (r == 2) a = 40'h0040000000 + 40'($urandom_range(0, 15));
            else begin
                a = BASE + 40'($urandom_range(0, MDL_BYTES - 8));
                if (r > 5) a = a & ~(40'(1 << sz) - 40'd1);
            end
            wd   = {$urandom, $urandom};
            kill = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LATENCY)) : 0;
            txn("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, kill);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
